// File: rtl/manycore_link_pkg.sv
// Shared types for the mesh link: port ids, framer states and Hermes header field offsets.
// Header layout puts addr_x in [15:8] and addr_y in [7:0] of the header flit.
package manycore_link_pkg;

   typedef enum logic [2:0] {
      EAST  = 3'd0,
      WEST  = 3'd1,
      NORTH = 3'd2,
      SOUTH = 3'd3,
      LOCAL = 3'd4
   } port_t;

   typedef enum logic [1:0] {
      HEADER,
      SIZE,
      PAYLOAD
   } frame_state_t;

   localparam int ADDR_X_MSB = 15;
   localparam int ADDR_Y_MSB = 7;

endpackage

// File: rtl/link_fifo.sv
// First-word fall-through FIFO with occupancy count; data visible 1 cycle after push.
// No internal guards: the caller must never push when full or pop when empty.
module link_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [W-1:0]               i_dat,
   input  logic                       i_pop,
   output logic [W-1:0]               o_dat,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // Storage has no reset so it maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_dat;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dat   = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/link_rx_port.sv
// Credit-based link receiver: buffers flits, returns credit from registered occupancy, frames Hermes packets.
// Push-to-visible latency 1 cycle; credit drops when full, ignored credit drops the flit and sets sticky ovf_o.
module link_rx_port
   import manycore_link_pkg::*;
#(
   parameter int FLIT_WIDTH   = 32,
   parameter int BUFFER_DEPTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx,
   input  logic [FLIT_WIDTH-1:0] data_i,
   output logic                  credit_o,
   output logic [FLIT_WIDTH-1:0] flit_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  sop_o,
   output logic                  eop_o,
   output logic [15:0]           target_o,
   output logic [15:0]           pkt_cnt_o,
   output logic                  ovf_o
);

   localparam int CW = $clog2(BUFFER_DEPTH) + 1;

   logic [CW-1:0]         w_count;
   logic [FLIT_WIDTH-1:0] w_flit;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_eop_raw;
   frame_state_t          w_state_nxt;
   logic [FLIT_WIDTH-1:0] w_rem_nxt;

   frame_state_t          r_state;
   logic [FLIT_WIDTH-1:0] r_rem;
   logic [15:0]           r_target;
   logic [15:0]           r_pkt_cnt;
   logic                  r_ovf;

   link_fifo #(
      .W     (FLIT_WIDTH),
      .DEPTH (BUFFER_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_dat   (data_i),
      .i_pop   (w_pop),
      .o_dat   (w_flit),
      .o_count (w_count)
   );

   // Credit looks only at registered occupancy so the sender sees it early in the cycle.
   assign credit_o = !reset && (w_count < CW'(BUFFER_DEPTH));
   assign valid_o  = (w_count != '0);
   assign w_push   = rx && credit_o;
   assign w_pop    = valid_o && ready_i;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (rx && !credit_o) begin
         r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= HEADER;
         r_rem     <= '0;
         r_target  <= '0;
         r_pkt_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         if (w_pop && (r_state == HEADER)) begin
            r_target <= {w_flit[ADDR_X_MSB:ADDR_Y_MSB+1], w_flit[ADDR_Y_MSB:0]};
         end
         if (w_pop && eop_o) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_eop_raw   = 1'b0;
      case (r_state)
         HEADER: begin
            if (w_pop) begin
               w_state_nxt = SIZE;
            end
         end
         SIZE: begin
            // A zero size flit closes the packet on itself.
            w_eop_raw = (w_flit == '0);
            if (w_pop) begin
               w_rem_nxt   = w_flit;
               w_state_nxt = w_eop_raw ? HEADER : PAYLOAD;
            end
         end
         PAYLOAD: begin
            w_eop_raw = (r_rem == FLIT_WIDTH'(1));
            if (w_pop) begin
               w_rem_nxt = r_rem - FLIT_WIDTH'(1);
               if (w_eop_raw) begin
                  w_state_nxt = HEADER;
               end
            end
         end
         default: begin
            w_state_nxt = HEADER;
         end
      endcase
   end

   assign flit_o    = w_flit;
   assign sop_o     = valid_o && (r_state == HEADER);
   assign eop_o     = valid_o && w_eop_raw;
   assign target_o  = r_target;
   assign pkt_cnt_o = r_pkt_cnt;
   assign ovf_o     = r_ovf;

endmodule
